// File: rtl/risc16_bus_pkg.sv
// Shared definitions for the RISC16 bus responder: I/O register map and
// the UART transmitter state encoding.
package risc16_bus_pkg;

    localparam logic [15:0] IO_LED01_ADDR  = 16'h0200;
    localparam logic [15:0] IO_LED2_ADDR   = 16'h0202;
    localparam logic [15:0] IO_TXDATA_ADDR = 16'h0204;
    localparam logic [15:0] IO_STATUS_ADDR = 16'h0206;

    // Upper 12 address bits shared by every location in 0x0200-0x020F.
    localparam logic [11:0] IO_WINDOW_TAG  = 12'h020;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    function automatic logic is_io_addr(input logic [15:0] addr);
        return addr[15:4] == IO_WINDOW_TAG;
    endfunction

endpackage

// File: rtl/risc16_uart_tx.sv
// TX FIFO plus 8N1 serializer for the bus responder.
//
// state    | meaning
// ---------+--------------------------------------------------------
// TX_IDLE  | line high; pops the FIFO as soon as it holds a byte
// TX_START | start bit (low) for CLKS_PER_BIT cycles
// TX_DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
// TX_STOP  | stop bit (high); chains straight into TX_START if data waits
//
// FIFO_DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module risc16_uart_tx
    import risc16_bus_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       clr_ovf,
    output logic       tx,
    output logic       tx_busy,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          full, empty, push_ok, pop;

    assign full    = (count_q == COUNT_FULL);
    assign empty   = (count_q == '0);
    // Fullness is judged before any same-cycle pop, so a push into a full
    // FIFO is dropped even while the serializer is draining it.
    assign push_ok = push && !full;

    // Serializer next-state: baud and bit timers count down to zero.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem[rd_ptr_q];
                    baud_d  = BAUD_LOAD;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_LOAD;
                    bit_d   = 3'd7;
                    state_d = TX_DATA;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            TX_DATA: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_LOAD;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd0) begin
                        state_d = TX_STOP;
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            TX_STOP: begin
                if (baud_q == '0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_mem[rd_ptr_q];
                        baud_d  = BAUD_LOAD;
                        state_d = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // FIFO bookkeeping, sticky overflow, and the registered line level.
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop);
        ovf_d    = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end else if (push && full) begin
            ovf_d = 1'b1;
        end
        tx_d = 1'b1;
        case (state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // State registers; reset drops any in-flight frame and queued bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= TX_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

    // FIFO storage needs no reset; the count decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= push_data;
        end
    end

    assign tx        = tx_q;
    assign fifo_full = full;
    assign overflow  = ovf_q;
    assign tx_busy   = (state_q != TX_IDLE) || !empty;

endmodule

// File: rtl/risc16_bus_responder.sv
// Memory and I/O responder for the RISC16 core: big-endian byte memory
// shared by data and instruction ports, LED registers, and an optional
// UART transmitter enabled by defining RISC16_UART_TX_EN.
module risc16_bus_responder
    import risc16_bus_pkg::*;
#(
    parameter int MEM_AW       = 12,
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] daddr,
    input  logic [15:0] ddout,
    output logic [15:0] ddin,
    input  logic        doe,
    input  logic        dwe,
    input  logic [15:0] iaddr,
    output logic [15:0] idin,
    input  logic        ioe,
    output logic [23:0] led,
    output logic        uart_tx
);

    localparam int MEM_BYTES = 1 << MEM_AW;
    localparam logic [15:0] IDX_MASK = 16'(MEM_BYTES - 2);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CLKS_PER_BIT < 1) begin : g_bad_cfg
        $error("risc16_bus_responder: FIFO_DEPTH must be a power of two >= 2, CLKS_PER_BIT >= 1");
    end

    logic [7:0]        mem_array [MEM_BYTES];
    logic [MEM_AW-1:0] d_hi_idx, d_lo_idx, i_hi_idx, i_lo_idx;
    logic              io_sel, mem_we;
    logic [15:0]       led01_q, led01_d;
    logic [7:0]        led2_q, led2_d;
    logic [15:0]       io_rdata, status_rdata;
    logic              unused_iaddr_bits;

    assign d_hi_idx = {daddr[MEM_AW-1:1], 1'b0};
    assign d_lo_idx = {daddr[MEM_AW-1:1], 1'b1};
    assign i_hi_idx = {iaddr[MEM_AW-1:1], 1'b0};
    assign i_lo_idx = {iaddr[MEM_AW-1:1], 1'b1};
    assign unused_iaddr_bits = |(iaddr & ~IDX_MASK);

    assign io_sel = is_io_addr(daddr);
    assign mem_we = dwe && !io_sel;

    // LED register next-state from data-port writes.
    always_comb begin
        led01_d = led01_q;
        led2_d  = led2_q;
        if (dwe && daddr == IO_LED01_ADDR) led01_d = ddout;
        if (dwe && daddr == IO_LED2_ADDR)  led2_d  = ddout[7:0];
    end

    // LED registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            led01_q <= '0;
            led2_q  <= '0;
        end else begin
            led01_q <= led01_d;
            led2_q  <= led2_d;
        end
    end

    // Backing memory: both bytes of the addressed word, never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_array[d_hi_idx] <= ddout[15:8];
            mem_array[d_lo_idx] <= ddout[7:0];
        end
    end

    // I/O read decode; holes in the window read as zero.
    always_comb begin
        io_rdata = 16'h0000;
        case (daddr)
            IO_LED01_ADDR:  io_rdata = led01_q;
            IO_LED2_ADDR:   io_rdata = {8'h00, led2_q};
            IO_STATUS_ADDR: io_rdata = status_rdata;
            default:        io_rdata = 16'h0000;
        endcase
    end

    // Same-cycle read data for both ports, zero while not enabled.
    always_comb begin
        ddin = 16'h0000;
        idin = 16'h0000;
        if (doe) ddin = io_sel ? io_rdata : {mem_array[d_hi_idx], mem_array[d_lo_idx]};
        if (ioe) idin = {mem_array[i_hi_idx], mem_array[i_lo_idx]};
    end

`ifdef RISC16_UART_TX_EN
    logic tx_busy, fifo_full, tx_overflow;

    risc16_uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) u_uart_tx (
        .clk       (clk),
        .rst       (rst),
        .push      (dwe && daddr == IO_TXDATA_ADDR),
        .push_data (ddout[7:0]),
        .clr_ovf   (dwe && daddr == IO_STATUS_ADDR),
        .tx        (uart_tx),
        .tx_busy   (tx_busy),
        .fifo_full (fifo_full),
        .overflow  (tx_overflow)
    );

    assign status_rdata = {13'b0, tx_overflow, fifo_full, tx_busy};
`else
    assign uart_tx      = 1'b1;
    assign status_rdata = 16'h0000;
`endif

    assign led = {led2_q, led01_q};

endmodule

// File: tb/tb_risc16_bus_responder.sv
module tb_risc16_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] daddr, ddout, ddin, iaddr, idin;
    logic        doe, dwe, ioe;
    logic [23:0] led;
    logic        uart_tx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    risc16_bus_responder #(
        .MEM_AW       (12),
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .daddr   (daddr),
        .ddout   (ddout),
        .ddin    (ddin),
        .doe     (doe),
        .dwe     (dwe),
        .iaddr   (iaddr),
        .idin    (idin),
        .ioe     (ioe),
        .led     (led),
        .uart_tx (uart_tx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        daddr = a;
        ddout = d;
        dwe   = 1'b1;
        @(posedge clk);
        #1;
        dwe = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk);
        daddr = a;
        doe   = 1'b1;
        #1;
        d   = ddin;
        doe = 1'b0;
    endtask

    task automatic ifetch(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk);
        iaddr = a;
        ioe   = 1'b1;
        #1;
        d   = idin;
        ioe = 1'b0;
    endtask

    // Mid-bit sampling receiver for CLKS_PER_BIT = 4.
    task automatic rx_byte(output logic [7:0] b, output logic stop_bit, output logic timed_out);
        logic found;
        found     = 1'b0;
        b         = 8'h00;
        stop_bit  = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (uart_tx === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        timed_out = !found;
        if (found) begin
            repeat (5) @(negedge clk);
            b[0] = uart_tx;
            for (int i = 1; i < 8; i++) begin
                repeat (4) @(negedge clk);
                b[i] = uart_tx;
            end
            repeat (4) @(negedge clk);
            stop_bit = uart_tx;
        end
    endtask

    logic [15:0] rd;
    logic        stayed_high;
`ifdef RISC16_UART_TX_EN
    logic [9:0]  frame_bits;
    logic [15:0] s1, s2;
    logic [7:0]  rx_data [5];
    logic        rx_stop [5];
    logic        rx_to   [5];
`endif

    initial begin
        rst   = 1'b1;
        daddr = '0;
        ddout = '0;
        iaddr = '0;
        doe   = 1'b0;
        dwe   = 1'b0;
        ioe   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_led", led, 24'h000000);
        check("rst_uart_tx", uart_tx, 1'b1);
        check("ddin_idle_zero", ddin, 16'h0000);
        check("idin_idle_zero", idin, 16'h0000);
        rst = 1'b0;
        bus_read(16'h0206, rd);
        check("rst_status", rd, 16'h0000);

        // Memory: big-endian word, a[0] ignored, wrap modulo 4 KiB
        bus_write(16'h0010, 16'h1234);
        bus_read(16'h0010, rd);
        check("mem_rd_0010", rd, 16'h1234);
        bus_read(16'h0011, rd);
        check("mem_rd_0011", rd, 16'h1234);
        ifetch(16'h0010, rd);
        check("ifetch_0010", rd, 16'h1234);
        bus_read(16'h1010, rd);
        check("mem_wrap_1010", rd, 16'h1234);
        bus_write(16'h0012, 16'h5678);
        ifetch(16'h0011, rd);
        check("ifetch_0011_neighbour", rd, 16'h1234);
        bus_write(16'h0210, 16'hBEEF);
        bus_read(16'h0210, rd);
        check("mem_just_above_io", rd, 16'hBEEF);

        // LEDs and I/O priority over memory
        bus_write(16'h1200, 16'h5A5A);
        bus_write(16'h0200, 16'hABCD);
        bus_write(16'h0202, 16'h00EF);
        @(negedge clk);
        check("led_value", led, 24'hEFABCD);
        bus_read(16'h0200, rd);
        check("io_rd_led01", rd, 16'hABCD);
        bus_read(16'h0202, rd);
        check("io_rd_led2", rd, 16'h00EF);
        ifetch(16'h0200, rd);
        check("mem_0200_unchanged", rd, 16'h5A5A);
        bus_read(16'h1200, rd);
        check("mem_alias_1200", rd, 16'h5A5A);
        bus_write(16'h0208, 16'h7777);
        bus_read(16'h0208, rd);
        check("io_unused_0208", rd, 16'h0000);
        bus_read(16'h020F, rd);
        check("io_unused_020F", rd, 16'h0000);
        check("led_after_unused_wr", led, 24'hEFABCD);

`ifdef RISC16_UART_TX_EN
        // Single frame, checked every cycle
        frame_bits = 10'b1_01010101_0;
        bus_write(16'h0204, 16'h0055);
        bus_read(16'h0206, rd);
        check("status_queued", rd, 16'h0001);
        check("tx_before_start", uart_tx, 1'b1);
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                check($sformatf("frame55_bit%0d_cyc%0d", b, c), uart_tx, frame_bits[b]);
                if (c == 2) begin
                    daddr = 16'h0206;
                    doe   = 1'b1;
                    #1;
                    check($sformatf("status_busy_bit%0d", b), ddin, 16'h0001);
                    doe = 1'b0;
                end
            end
        end
        bus_read(16'h0206, rd);
        check("status_after_frame", rd, 16'h0000);
        check("tx_after_frame", uart_tx, 1'b1);

        // Six writes into a 4-deep FIFO while the first frame is active
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    bus_write(16'h0204, 16'h0011 + 16'(i));
                end
                bus_read(16'h0206, s1);
                bus_write(16'h0206, 16'h0000);
                bus_read(16'h0206, s2);
            end
            begin
                for (int j = 0; j < 5; j++) begin
                    rx_byte(rx_data[j], rx_stop[j], rx_to[j]);
                end
            end
        join
        check("status_overflow", s1, 16'h0007);
        check("status_ovf_cleared", s2, 16'h0003);
        for (int j = 0; j < 5; j++) begin
            check($sformatf("rx_timeout_%0d", j), rx_to[j], 1'b0);
            check($sformatf("rx_byte_%0d", j), rx_data[j], 8'h11 + 8'(j));
            check($sformatf("rx_stop_%0d", j), rx_stop[j], 1'b1);
        end
        stayed_high = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) stayed_high = 1'b0;
        end
        check("sixth_byte_dropped", stayed_high, 1'b1);
        bus_read(16'h0206, rd);
        check("status_drained", rd, 16'h0000);

        // Reset in the middle of a data bit
        bus_write(16'h0200, 16'h1357);
        bus_write(16'h0030, 16'hCAFE);
        bus_write(16'h0204, 16'h00A5);
        repeat (10) @(negedge clk);
        check("pre_reset_data_bit1", uart_tx, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_tx_line", uart_tx, 1'b1);
        check("rst_mid_led", led, 24'h000000);
        daddr = 16'h0206;
        doe   = 1'b1;
        #1;
        check("rst_mid_status", ddin, 16'h0000);
        doe = 1'b0;
        rst = 1'b0;
        stayed_high = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) stayed_high = 1'b0;
        end
        check("rst_frame_lost", stayed_high, 1'b1);
        bus_read(16'h0030, rd);
        check("rst_mem_preserved", rd, 16'hCAFE);
        ifetch(16'h0030, rd);
        check("rst_mem_preserved_i", rd, 16'hCAFE);
`else
        // Build without the transmitter
        bus_write(16'h0204, 16'h0055);
        stayed_high = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) stayed_high = 1'b0;
        end
        check("notx_line_idle", stayed_high, 1'b1);
        bus_read(16'h0206, rd);
        check("notx_status", rd, 16'h0000);
        bus_write(16'h0206, 16'hFFFF);
        bus_read(16'h0206, rd);
        check("notx_status_after_wr", rd, 16'h0000);
        check("notx_led_untouched", led, 24'hEFABCD);
        bus_read(16'h0010, rd);
        check("notx_mem_intact", rd, 16'h1234);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/risc16_bus_responder.md
RISC16_BUS_RESPONDER -- requirements
Module: risc16_bus_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 12, byte-address bits of the backing memory (2**MEM_AW bytes).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 217, clk cycles per UART bit (25 MHz / 115200).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, UART TX FIFO entries (power of two).
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port daddr  in  16  CPU data byte address.
REQ-007 SHALL have port ddout  in  16  CPU write data.
REQ-008 SHALL have port ddin  out  16  read data to CPU.
REQ-009 SHALL have ports doe / dwe  in  1 each  data read enable / data write enable.
REQ-010 SHALL have ports iaddr  in  16, idin  out  16, ioe  in  1  instruction fetch port.
REQ-011 SHALL have port led  out  24  {led_2, led_1, led_0}.
REQ-012 SHALL have port uart_tx  out  1  serial line, idle high.

Function
REQ-013 SHALL decode ddin and idin combinationally in the same cycle as doe/ioe, and drive 16'h0000 while the enable is low.
REQ-014 SHALL store memory big-endian: word = {mem[a & ~1], mem[a | 1]}, indexed by a[MEM_AW-1:0]; addresses wrap modulo 2**MEM_AW; a[0] ignored.
REQ-015 SHALL decode I/O window 0x0200-0x020F with priority over memory for daddr only; I/O writes never update memory; iaddr always reads memory.
REQ-016 SHALL write memory on the rising edge when dwe=1, both bytes.
REQ-017 SHALL on write 0x0200 load led_1=ddout[15:8] and led_0=ddout[7:0]; read returns {led_1, led_0}.
REQ-018 SHALL on write 0x0202 load led_2=ddout[7:0]; read returns {8'h00, led_2}.
REQ-019 SHALL on write 0x0204 push ddout[7:0] into the TX FIFO if not full (full evaluated before any same-cycle pop); otherwise drop the byte and set sticky overflow.
REQ-020 SHALL on read 0x0206 return {13'b0, overflow, fifo_full, tx_busy}; any write to 0x0206 clears overflow (clear wins over a same-cycle set).
REQ-021 SHALL return 16'h0000 for reads of unused I/O addresses and ignore writes to them.
REQ-022 SHALL run TX FSM IDLE -> START -> DATA -> STOP -> IDLE, each bit CLKS_PER_BIT cycles, 8N1, LSB first.
REQ-023 SHALL pop the FIFO in IDLE when not empty, driving start bit from the next cycle; tx_busy=1 outside IDLE or when FIFO not empty.
REQ-024 SHALL, at end of STOP with FIFO non-empty, pop and enter START directly (back-to-back frames, no idle gap).
REQ-025 SHALL handle FIFO pointers with wrap-around modulo FIFO_DEPTH and an explicit count of 0..FIFO_DEPTH.

Reset
REQ-026 SHALL on rst set led=24'h0, uart_tx=1, FIFO empty, overflow=0, FSM IDLE, bit counters 0, effective next edge.
REQ-027 SHALL abort an in-flight frame on reset (line high next cycle, byte lost); memory contents are not reset.

Configuration
REQ-028 SHALL with macro RISC16_UART_TX_EN defined implement REQ-019..REQ-025.
REQ-029 SHALL without RISC16_UART_TX_EN tie uart_tx=1, ignore writes to 0x0204/0x0206, read 0x0206 as 16'h0000, instantiate no FIFO or FSM.

Structure
REQ-030 SHALL place I/O address constants (0x0200/0x0202/0x0204/0x0206) and the TX state enum in package risc16_bus_pkg.
REQ-031 SHALL implement FIFO plus serializer as sub-module risc16_uart_tx, instantiated only under RISC16_UART_TX_EN.

Verification
REQ-032 SHALL test: write 0x1234 to 0x0010, read 0x0010 and 0x0011 -> ddin=0x1234; idin at iaddr=0x0010 = 0x1234.
REQ-033 SHALL test: write 0xABCD to 0x0200, 0x00EF to 0x0202 -> led=0xEFABCD; memory at 0x0200 unchanged.
REQ-034 SHALL test (CLKS_PER_BIT=4): write 0x0055 to 0x0204 -> uart_tx 0,1,0,1,0,1,0,1,0,1 per 4-cycle bit; status 0x0001 during frame, 0x0000 after.
REQ-035 SHALL test: 6 back-to-back writes to 0x0204 at FIFO_DEPTH=4 while busy -> 5 bytes sent (1 popped + 4 queued), byte 6 dropped, status bit2=1; write 0x0206 clears it.
REQ-036 SHALL test: rst asserted mid-DATA -> uart_tx=1, status 0x0000, led=0 next cycle; memory preserved.
REQ-037 SHALL test: build without RISC16_UART_TX_EN -> uart_tx stays 1, 0x0206 reads 0x0000.
